fetch_queue: RTL
================

# fetch_queue

Parametrised instruction-fetch front end for the RV32I core. It generalises the fetch portion of the single-cycle top (PC register plus asynchronous instruction memory) into a decoupled unit. The unit has a program counter, a start/halt controller driven by `trigger`, and a DEPTH-entry prefetch queue with a valid/ready handshake toward decode. Branch/jump redirects flush the queue. It sits between `InstrMem` and the decode/control stage of the pipelined core.

## Interface
- `XLEN`, 32, width of PC and instruction words.
- `DEPTH`, 4, queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0, PC loaded at reset.

Ports:
- `clk`  in  1  the single clock. All state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low (`rst`=0 resets on the next rising edge).
- `trigger`  in  1  start fetching; sampled in IDLE.
- `imem_addr`  out  XLEN  fetch address, equal to `fetch_pc`.
- `imem_en`  out  1  a fetch is being pushed this cycle.
- `imem_data`  in  XLEN  instruction at `imem_addr`, combinational, same cycle.
- `redirect_valid`  in  1  flush and restart at `redirect_pc`.
- `redirect_pc`  in  XLEN  new fetch address; bits [1:0] ignored and forced to 0.
- `out_valid`  out  1  queue head valid.
- `out_ready`  in  1  decode accepts head.
- `out_instr`  out  XLEN  head instruction.
- `out_pc`  out  XLEN  head PC.
- `out_inc_pc`  out  XLEN  head PC + 4, mod 2^XLEN.
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `running`  out  1  FSM is in RUN.

## Operation
- FSM states: IDLE, RUN, HALT (HALT exists only with macro).
  - IDLE→RUN when `trigger`=1.
  - RUN→HALT on halt instruction push (see Configuration).
  - HALT→RUN on `redirect_valid`.
  - Any state→IDLE on reset.
- Push: in RUN, when not redirecting, and (`count`<DEPTH or a pop occurs this cycle). The push writes {`fetch_pc`, `imem_data`} at the tail, `fetch_pc` ← `fetch_pc`+4 (wraps modulo 2^XLEN), and `imem_en`=1.
- Pop: `out_valid` && `out_ready`. The head advances.
- Push and pop in the same cycle leave `count` unchanged. Full+pop+push is legal.
- `out_valid` = (`count`≠0). Head fields are driven from registers only, with no combinational path from `imem_data`.
- Redirect (any state):
  - Queue cleared (`count`←0) and `fetch_pc`←{`redirect_pc`[XLEN-1:2],2'b00}.
  - No push and no pop that cycle; a same-cycle `out_ready` handshake is discarded.
  - In IDLE the redirect loads `fetch_pc` but stays in IDLE.
- `trigger` in RUN/HALT is ignored.
- Priority: reset > redirect > pop/push.

## Timing
- Reset values:
  - state IDLE, `fetch_pc`=RESET_PC, `count`=0.
  - `out_valid`=0, `imem_en`=0, `running`=0.
  - `out_instr`=0, `out_pc`=0, `out_inc_pc`=4.
- `trigger` high at edge N → RUN after N. The first push happens at edge N+1, and the first `out_valid`=1 occurs after N+1.
  - Fetch-to-output latency is 1 cycle.
  - Throughput is 1 instr/cycle with `out_ready` held high.
- Redirect at edge R: `out_valid`=0 after R. The push from `redirect_pc` happens at R+1, and that entry is valid after R+1.
- Reset asserted mid-operation: all state returns to reset values on that edge. Queue contents are discarded.

## Configuration
- `FETCH_HALT_EN` defined:
  - Pushing instruction 32'h00100073 (EBREAK) enqueues it normally and moves the FSM to HALT.
  - In HALT there are no further pushes and `imem_en`=0. The queue still drains.
  - Exit from HALT only via redirect (→RUN) or reset.
- `FETCH_HALT_EN` undefined: EBREAK is an ordinary instruction, and the HALT state and its logic are absent.

## Test plan
- Reset: hold `rst`=0 two cycles with `trigger`=1 → `out_valid`=0, `count`=0, `imem_addr`=RESET_PC, `running`=0.
- Fill/stall: `trigger` pulse, `out_ready`=0, imem returns addr^32'hA5A5_0000 → `count` reaches 4 after 4 pushes. Entries have PCs 0,4,8,C. `imem_en`=0 while full; head stays PC 0.
- Stream: from full, `out_ready`=1 for 8 cycles → one pop per cycle with PCs 0,4,…,1C in order. `count` stays 4.
- Redirect: mid-stream `redirect_valid`=1, `redirect_pc`=32'h0000_0103 → next cycle `out_valid`=0 and `count`=0. The following cycle the head is PC 32'h100 with `out_inc_pc`=32'h104.
- Wrap: redirect to 32'hFFFF_FFF8 → pushed PCs FFFF_FFF8, FFFF_FFFC, 0000_0000. `out_inc_pc` of FFFF_FFFC is 0.
- Halt (`FETCH_HALT_EN`): EBREAK at PC 8 → PCs 0,4,8 are delivered and `running`=0 with no PC C fetched. Redirect to 0x40 → resumes at 0x40.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: fetch_queue bundle; master is the fetch unit, slave is the imem/decode side
interface fetch_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                     trigger;
  logic [XLEN-1:0]          imem_addr;
  logic                     imem_en;
  logic [XLEN-1:0]          imem_data;
  logic                     redirect_valid;
  logic [XLEN-1:0]          redirect_pc;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          out_instr;
  logic [XLEN-1:0]          out_pc;
  logic [XLEN-1:0]          out_inc_pc;
  logic [$clog2(DEPTH):0]   count;
  logic                     running;
  modport master (
    input  trigger, imem_data, redirect_valid, redirect_pc, out_ready,
    output imem_addr, imem_en, out_valid, out_instr, out_pc, out_inc_pc, count, running
  );
  modport slave (
    output trigger, imem_data, redirect_valid, redirect_pc, out_ready,
    input  imem_addr, imem_en, out_valid, out_instr, out_pc, out_inc_pc, count, running
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: PC + start/halt FSM + DEPTH-entry prefetch queue toward decode.
// Define FETCH_HALT_EN to stop fetching after an EBREAK is enqueued.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef FETCH_HALT_EN
  localparam logic [XLEN-1:0] EBREAK = XLEN'(32'h0010_0073);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
`else
  typedef enum logic {IDLE, RUN} state_t;
`endif
  state_t          state, state_nx;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] instr_q [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   cnt;
  logic            redir, push, pop;
  assign redir = bus.redirect_valid;
  assign pop   = bus.out_valid && bus.out_ready && !redir;
  assign push  = state == RUN && !redir && (cnt < CW'(DEPTH) || pop);
  always_comb begin
    state_nx = state;
    if (redir)
      state_nx = state == IDLE ? IDLE : RUN;
    else if (state == IDLE && bus.trigger)
      state_nx = RUN;
`ifdef FETCH_HALT_EN
    else if (push && bus.imem_data == EBREAK)
      state_nx = HALT;
`endif
  end
  always_ff @(posedge clk)
    state <= !rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
    end else if (redir) begin
      fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
    end else begin
      if (push) fetch_pc <= fetch_pc + XLEN'(4);
      tail <= tail + AW'(push);
      head <= head + AW'(pop);
      cnt  <= cnt + CW'(push) - CW'(pop);
    end
  end
  // Storage is unreset; head outputs are gated by count instead.
  always_ff @(posedge clk)
    if (rst && push) begin
      pc_q[tail]    <= fetch_pc;
      instr_q[tail] <= bus.imem_data;
    end
  assign bus.imem_addr  = fetch_pc;
  assign bus.imem_en    = push;
  assign bus.out_valid  = cnt != '0;
  assign bus.out_pc     = bus.out_valid ? pc_q[head] : '0;
  assign bus.out_instr  = bus.out_valid ? instr_q[head] : '0;
  assign bus.out_inc_pc = bus.out_pc + XLEN'(4);
  assign bus.count      = cnt;
  assign bus.running    = state == RUN;
endmodule
